// File: rtl/counter32_sched_if.sv
// counter32_sched_if: requester-side and counter-side signals of the scheduler.
//   master modport: the scheduler (drives GNT/DONE/BUSY and counter controls).
//   slave modport : the environment (requesters plus the counter32 cell).
interface counter32_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  // Requester side
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DELAY;
  logic [NREQ-1:0]       GNT;
  logic [NREQ-1:0]       DONE;
  logic                  BUSY;
  // Counter side
  logic                  CNT_RESETSIG;
  logic                  CNT_PRESET;
  logic [WIDTH-1:0]      CNT_PRESETVAL;
  logic                  CNT_ENABLE;
  logic                  CNT_DIR;
  logic                  CNT_ZERO;

  modport master (
    input  REQ, DELAY, CNT_ZERO,
    output GNT, DONE, BUSY,
    output CNT_RESETSIG, CNT_PRESET, CNT_PRESETVAL, CNT_ENABLE, CNT_DIR
  );

  modport slave (
    output REQ, DELAY, CNT_ZERO,
    input  GNT, DONE, BUSY,
    input  CNT_RESETSIG, CNT_PRESET, CNT_PRESETVAL, CNT_ENABLE, CNT_DIR
  );
endinterface

// File: rtl/counter32_sched.sv
// counter32_sched: round-robin scheduler sharing one counter32 cell among NREQ requesters.
// Latency: REQ sampled in IDLE cycle t0 -> GNT in t0+1, DONE pulse in t0+DELAY+3; per-job occupancy DELAY+4.
// Backpressure: level-based REQ held until DONE; no grant is issued while a job occupies the counter.
//
// Ports:
//   CLK, SRST      clock, synchronous active-high reset (overrides everything, aborts a running job silently)
//   bus.REQ/DELAY  per-requester request level and delay (slice i = DELAY[i*WIDTH +: WIDTH])
//   bus.GNT/DONE   one-hot grant and one-cycle one-hot completion pulse, both registered
//   bus.BUSY       high whenever the FSM is not IDLE
//   bus.CNT_*      control of the counter32 cell; CNT_ENABLE is combinational from CNT_ZERO
// Optional feature macro: COUNTER32_SCHED_CANCEL_EN (dropping REQ of the granted requester aborts its job).
module counter32_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input logic               CLK,
  input logic               SRST,
  counter32_sched_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q,   ptr_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [NREQ-1:0]   done_q,  done_d;
  logic              busy_q,  busy_d;
  logic              preset_q, preset_d;
  logic [WIDTH-1:0]  pval_q,  pval_d;
  logic              cnt_en;

  // Per-requester delay view of the flat DELAY bus.
  logic [WIDTH-1:0]  delay_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      delay_arr[i] = bus.DELAY[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: first set REQ bit at or after ptr_q, wrapping modulo NREQ.
  // The scan runs from the farthest candidate back to ptr_q so the nearest
  // requesting index is the last one written.
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (bus.REQ[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Pointer value used whenever a job ends (normally or by abort).
  logic [IW-1:0]     ptr_next;
  assign ptr_next = IW'((int'(idx_q) + 1) % NREQ);

`ifdef COUNTER32_SCHED_CANCEL_EN
  logic              rstsig_q, rstsig_d;
  logic              abort;
  // The granted requester withdrawing during LOAD or RUN kills the job;
  // this takes priority over a coincident CNT_ZERO in RUN.
  assign abort = ((state_q == S_LOAD) || (state_q == S_RUN)) && !bus.REQ[idx_q];
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    preset_d = 1'b0;
    pval_d   = pval_q;
    cnt_en   = 1'b0;
`ifdef COUNTER32_SCHED_CANCEL_EN
    rstsig_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          idx_d    = pick_idx;
          gnt_d    = NREQ'(1) << pick_idx;
          busy_d   = 1'b1;
          // Preset strobe and value are registered so they appear during LOAD.
          preset_d = 1'b1;
          pval_d   = delay_arr[pick_idx];
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        // Gated by CNT_ZERO in the same cycle so the counter stops at zero.
        cnt_en = !bus.CNT_ZERO;
        if (bus.CNT_ZERO) begin
          done_d  = gnt_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef COUNTER32_SCHED_CANCEL_EN
    if (abort) begin
      cnt_en   = 1'b0;
      done_d   = '0;
      gnt_d    = '0;
      busy_d   = 1'b0;
      ptr_d    = ptr_next;
      rstsig_d = 1'b1;
      state_d  = S_IDLE;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      preset_q <= 1'b0;
      pval_q   <= '0;
`ifdef COUNTER32_SCHED_CANCEL_EN
      rstsig_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      preset_q <= preset_d;
      pval_q   <= pval_d;
`ifdef COUNTER32_SCHED_CANCEL_EN
      rstsig_q <= rstsig_d;
`endif
    end
  end

  assign bus.GNT           = gnt_q;
  assign bus.DONE          = done_q;
  assign bus.BUSY          = busy_q;
  assign bus.CNT_PRESET    = preset_q;
  assign bus.CNT_PRESETVAL = pval_q;
  assign bus.CNT_ENABLE    = cnt_en;
  assign bus.CNT_DIR       = 1'b0;
`ifdef COUNTER32_SCHED_CANCEL_EN
  assign bus.CNT_RESETSIG  = rstsig_q;
`else
  assign bus.CNT_RESETSIG  = 1'b0;
`endif

endmodule

// File: tb/tb_counter32_sched.sv
// tb_counter32_sched: randomized and directed stimulus for counter32_sched.
// A job-level reference model (cycle arithmetic on grant/done times) predicts every
// preset and DONE; a monitor on the opposite clock edge pops and compares.
`timescale 1ns/1ps
module tb_counter32_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic CLK  = 1'b0;
  logic SRST = 1'b1;
  always #5 CLK = ~CLK;

  counter32_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  counter32_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.CLK(CLK), .SRST(SRST), .bus(bus));

  // Behavioural counter32 cell driven by the scheduler.
  logic [WIDTH-1:0] cnt = '0;
  always @(posedge CLK) begin
    if (bus.CNT_RESETSIG)    cnt <= '0;
    else if (bus.CNT_PRESET) cnt <= bus.CNT_PRESETVAL;
    else if (bus.CNT_ENABLE) cnt <= bus.CNT_DIR ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign bus.CNT_ZERO = (cnt == '0);

  typedef struct { int idx; int t; int dly; } job_t;
  job_t load_q[$];
  job_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  // Reference model state (job level)
  int free_t   = 0;   // first cycle in which the scheduler is IDLE again
  int ptr_m    = 0;
  int busy_lo  = -1;
  int busy_hi  = -1;
  int last_idx = 0;
  int rst_t    = -1;  // cycle in which CNT_RESETSIG must be high
  int cur_idx  = -1, cur_g = 0, cur_d = 0;

  // Requester behaviour
  bit active [NREQ];
  int rq_dly [NREQ];
  int rq_done[NREQ];
  bit auto_en = 0;
  int p_raise = 0, p_keep = 0, fix_dly = -1;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int new_dly();
    if (fix_dly >= 0) return fix_dly;
    return ($urandom_range(3) == 0) ? int'($urandom_range(40)) : int'($urandom_range(6));
  endfunction

  task automatic arm(int i, int d);
    active[i]  = 1'b1;
    rq_dly[i]  = d;
    rq_done[i] = -1;
  endtask

  task automatic update_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (active[i] && rq_done[i] >= 0 && cyc == rq_done[i] + 1) begin
        rq_done[i] = -1;
        if (int'($urandom_range(99)) < p_keep) rq_dly[i] = new_dly();
        else active[i] = 1'b0;
      end
      if (!active[i]) begin
        rq_dly[i] = int'($urandom);  // idle requesters present junk delays
        if (auto_en && int'($urandom_range(99)) < p_raise) arm(i, new_dly());
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.REQ[i] = active[i];
      bus.DELAY[i*WIDTH +: WIDTH] = WIDTH'(rq_dly[i]);
    end
  endtask

  task automatic model_cycle();
    job_t tmp[$];
    int   idx;
    bit   found;
    if (SRST) begin
      foreach (done_q[k]) if (done_q[k].t <= cyc) tmp.push_back(done_q[k]);
      done_q = tmp;
      tmp = {};
      foreach (load_q[k]) if (load_q[k].t <= cyc) tmp.push_back(load_q[k]);
      load_q = tmp;
      for (int i = 0; i < NREQ; i++) if (rq_done[i] > cyc) rq_done[i] = -1;
      if (busy_hi > cyc) busy_hi = cyc;
      if (rst_t > cyc) rst_t = -1;
      free_t  = cyc + 1;
      ptr_m   = 0;
      cur_idx = -1;
      return;
    end
`ifdef COUNTER32_SCHED_CANCEL_EN
    if (cur_idx >= 0 && cyc > cur_g && cyc <= cur_g + cur_d + 2 && !bus.REQ[cur_idx]) begin
      void'(done_q.pop_back());
      rq_done[cur_idx] = -1;
      busy_hi = cyc;
      free_t  = cyc + 1;
      ptr_m   = (cur_idx + 1) % NREQ;
      rst_t   = cyc + 1;
      cur_idx = -1;
    end
`endif
    if (cyc >= free_t && bus.REQ != '0) begin
      found = 0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && bus.REQ[(ptr_m + k) % NREQ]) begin
          found = 1;
          idx   = (ptr_m + k) % NREQ;
        end
      end
      load_q.push_back('{idx, cyc + 1, rq_dly[idx]});
      done_q.push_back('{idx, cyc + rq_dly[idx] + 3, rq_dly[idx]});
      rq_done[idx] = cyc + rq_dly[idx] + 3;
      busy_lo  = cyc;
      busy_hi  = cyc + rq_dly[idx] + 3;
      free_t   = cyc + rq_dly[idx] + 4;
      ptr_m    = (idx + 1) % NREQ;
      last_idx = idx;
      cur_idx  = idx; cur_g = cyc; cur_d = rq_dly[idx];
    end
  endtask

  task automatic tick(bit rst);
    @(posedge CLK);
    #1;
    cyc++;
    mon_en = 1;
    SRST = rst;
    update_reqs();
    drive();
    model_cycle();
  endtask

  task automatic drain(int max_cyc);
    int n;
    bit busy_any;
    n = 0;
    busy_any = 1;
    while (busy_any && n < max_cyc) begin
      tick(0);
      n++;
      busy_any = (done_q.size() != 0) || (load_q.size() != 0) || (cyc <= busy_hi);
      for (int i = 0; i < NREQ; i++) if (active[i]) busy_any = 1;
    end
    if (busy_any) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout at cycle %0d: %0d jobs still pending after %0d cycles",
               cyc, done_q.size(), max_cyc);
    end
  endtask

  // Monitor / scoreboard
  int   en_cnt = 0;
  job_t j;
  bit   eb;
  always @(negedge CLK) begin
    if (mon_en) begin
      eb = (cyc > busy_lo) && (cyc <= busy_hi);
      check("busy", bus.BUSY, eb);
      if (!eb) begin
        check("gnt_idle", bus.GNT, 0);
        check("preset_idle", bus.CNT_PRESET, 0);
      end else if (cyc != busy_hi) begin
        check("gnt_held", bus.GNT, 1 << last_idx);
      end
      check("resetsig", bus.CNT_RESETSIG, cyc == rst_t);
      if (bus.CNT_PRESET) begin
        en_cnt = 0;
        if (load_q.size() == 0) begin
          check("preset_unexpected", bus.CNT_PRESETVAL, -1);
        end else begin
          j = load_q.pop_front();
          check("preset_cycle", cyc, j.t);
          check("preset_val", bus.CNT_PRESETVAL, j.dly);
          check("gnt_at_load", bus.GNT, 1 << j.idx);
        end
      end
      if (bus.CNT_ENABLE) begin
        if (cnt == '0) check("enable_at_zero", bus.CNT_ENABLE, 0);
        en_cnt++;
      end
      if (bus.DONE != '0) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", bus.DONE, 0);
        end else begin
          j = done_q.pop_front();
          check("done_idx", bus.DONE, 1 << j.idx);
          check("done_cycle", cyc, j.t);
          check("enable_cycles", en_cnt, j.dly);
        end
      end
      while (done_q.size() != 0 && done_q[0].t < cyc) begin
        j = done_q.pop_front();
        check("done_missing", j.t, -1);
      end
      while (load_q.size() != 0 && load_q[0].t < cyc) begin
        j = load_q.pop_front();
        check("preset_missing", j.t, -1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      active[i]  = 1'b0;
      rq_dly[i]  = 0;
      rq_done[i] = -1;
    end
    // Reset with every requester asserted; first grant afterwards must be requester 0.
    for (int i = 0; i < NREQ; i++) arm(i, 3);
    drive();
    tick(1);
    tick(1);
    drain(200);

    // Single job, DELAY 5 on requester 2.
    arm(2, 5);
    drain(100);

    // Zero delay on requester 0.
    arm(0, 0);
    drain(100);

    // All requesting continuously with DELAY 1: strict rotation, 5 cycles apart.
    fix_dly = 1;
    p_keep  = 100;
    for (int i = 0; i < NREQ; i++) arm(i, 1);
    repeat (42) tick(0);
    p_keep  = 0;
    fix_dly = -1;
    drain(100);

    // Reset 20 cycles into RUN of a long job; requester 0 joins at reset.
    arm(1, 100);
    tick(0);
    repeat (21) tick(0);
    arm(0, 4);
    tick(1);
    drain(300);

    // Requester 3 withdraws during RUN of a 50-cycle job.
    arm(3, 50);
    tick(0);
    repeat (10) tick(0);
    active[3] = 1'b0;
    drain(200);
    // Pointer must have moved past 3: with 0 and 1 requesting, 0 goes first.
    arm(1, 2);
    arm(0, 2);
    drain(100);

    // Random traffic with occasional resets.
    auto_en = 1;
    p_raise = 20;
    p_keep  = 40;
    repeat (2500) tick($urandom_range(299) == 0);
    auto_en = 0;
    p_keep  = 0;
    drain(3000);

    check("cnt_dir", bus.CNT_DIR, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
